// File: rtl/srg_mips_pkg.sv
// srg_mips_pkg: shared opcode/funct codes, ALU OperationSelect codes and control FSM states.
package srg_mips_pkg;
    localparam int OP_W = 6;
    localparam int FN_W = 6;
    localparam int ST_W = 4;

    localparam logic [OP_W-1:0] OP_R    = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
    localparam logic [OP_W-1:0] OP_J    = 6'b000010;

    localparam logic [FN_W-1:0] FN_AND = 6'b100100;
    localparam logic [FN_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FN_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FN_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FN_W-1:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [ST_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        RTYPE_EX = 4'd6,
        ALUWB    = 4'd7,
        ADDI_EX  = 4'd8,
        ADDI_WB  = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11
    } state_t;
endpackage

// File: rtl/srg_alu_dec.sv
// srg_alu_dec: R-type funct -> ALU OperationSelect; unknown funct falls back to ADD and flags illegal.
module srg_alu_dec
    import srg_mips_pkg::*;
(
    input  logic [FN_W-1:0] funct,
    output logic [2:0]      alu_sel,
    output logic            illegal
);
    always_comb begin
        alu_sel = ALU_ADD;
        illegal = 1'b0;
        case (funct)
            FN_AND:  alu_sel = ALU_AND;
            FN_OR:   alu_sel = ALU_OR;
            FN_ADD:  alu_sel = ALU_ADD;
            FN_SUB:  alu_sel = ALU_SUB;
            FN_SLT:  alu_sel = ALU_SLT;
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/srg_mips_mc_ctrl.sv
// srg_mips_mc_ctrl: multicycle MIPS control FSM driving datapath enables, muxes and ALU select.
module srg_mips_mc_ctrl
    import srg_mips_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] opcode,
    input  logic [FN_W-1:0] funct,
    input  logic            alu_zero,
    output logic            pc_en,
    output logic            i_or_d,
    output logic            mem_write,
    output logic            ir_write,
    output logic            reg_write,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      pc_src,
    output logic [2:0]      alu_sel,
    output logic            instr_done,
    output logic            illegal_op,
    output logic [ST_W-1:0] dbg_state
);
    state_t     state, nxt;
    logic [2:0] fn_sel;
    logic       fn_bad, op_bad;

    srg_alu_dec u_dec (.funct(funct), .alu_sel(fn_sel), .illegal(fn_bad));

    assign op_bad    = !(opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= nxt;
    end

    always_comb begin
        nxt = FETCH;
        case (state)
            FETCH:    nxt = DECODE;
            DECODE:   case (opcode)
                          OP_R:         nxt = RTYPE_EX;
                          OP_LW, OP_SW: nxt = MEMADR;
                          OP_BEQ:       nxt = BRANCH;
                          OP_ADDI:      nxt = ADDI_EX;
                          OP_J:         nxt = JUMP;
                          default:      nxt = FETCH;
                      endcase
            MEMADR:   nxt = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:    nxt = MEMWB;
            RTYPE_EX: nxt = ALUWB;
            ADDI_EX:  nxt = ADDI_WB;
            default:  nxt = FETCH;
        endcase
    end

    // Outputs are decoded from state and held at their idle values throughout reset.
    always_comb begin
        pc_en      = 1'b0;
        i_or_d     = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_sel    = ALU_ADD;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        if (!rst) begin
            case (state)
                FETCH:    begin ir_write = 1'b1; pc_en = 1'b1; alu_src_b = 2'b01; end
                DECODE:   begin
                    alu_src_b  = 2'b11;
                    illegal_op = op_bad || (opcode == OP_R && fn_bad);
                    instr_done = op_bad;
                end
                MEMADR:   begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
                MEMRD:    i_or_d = 1'b1;
                MEMWB:    begin reg_write = 1'b1; mem_to_reg = 1'b1; instr_done = 1'b1; end
                MEMWR:    begin i_or_d = 1'b1; mem_write = 1'b1; instr_done = 1'b1; end
                RTYPE_EX: begin alu_src_a = 1'b1; alu_sel = fn_sel; end
                ALUWB:    begin reg_write = 1'b1; reg_dst = 1'b1; instr_done = 1'b1; end
                ADDI_EX:  begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
                ADDI_WB:  begin reg_write = 1'b1; instr_done = 1'b1; end
                BRANCH:   begin
                    alu_src_a  = 1'b1;
                    alu_sel    = ALU_SUB;
                    pc_src     = 2'b01;
                    pc_en      = alu_zero;
                    instr_done = 1'b1;
                end
                JUMP:     begin pc_src = 2'b10; pc_en = 1'b1; instr_done = 1'b1; end
                default:  ;
            endcase
        end
    end
endmodule
